hazard_ctrl_pipe: RTL and testbench
===================================

HAZARD_CTRL_PIPE -- requirements
Module: hazard_ctrl_pipe

Interface
REQ-001 clk  input  1  rising-edge pipeline clock.
REQ-002 reset_n  input  1  asynchronous active-low reset.
REQ-003 id_ctrl  input  lc3b_control_word  decoded control word of the instruction in ID.
REQ-004 id_valid  input  1  ID holds a real instruction.
REQ-005 id_dest  input  3  resolved destination register (R7 already substituted for JSR/TRAP).
REQ-006 id_sr1, id_sr2  input  3 each  source register numbers.
REQ-007 id_sr1_used, id_sr2_used  input  1 each  the source is actually read.
REQ-008 mem_ready  input  1  data memory has completed the MEM-stage access.
REQ-009 mem_br_taken  input  1  MEM-stage redirect (branch taken, JMP, JSR, TRAP).
REQ-010 ex_ctrl, mem_ctrl, wb_ctrl  output  lc3b_control_word  stage control words.
REQ-011 ex_valid, mem_valid, wb_valid  output  1 each  stage-valid bits.
REQ-012 ex_dest, mem_dest, wb_dest  output  3 each  destination register per stage.
REQ-013 id_stall  output  1  hold PC and IF/ID this cycle.
REQ-014 flush  output  1  squash IF/ID this cycle.

Function
REQ-015 Bubble: control word all-zero, valid 0, dest 0.
REQ-016 mem_op: mem_valid and mem_ctrl.opcode in {LDR, STR, LDB, STB, LDI, STI, TRAP}.
REQ-017 FSM states RUN, LD_STALL, MEM_WAIT.
REQ-018 RUN/LD_STALL, no hazard or flush: each edge moves ID->EX, EX->MEM, MEM->WB, together with ctrl, valid and dest.
REQ-019 Load-use hazard: ex_valid, ex_ctrl.load_hazard and ex_ctrl.load_regfile are all 1, id_valid is 1, and a used source equals ex_dest.
- id_stall=1 combinationally.
- EX receives a bubble at the next edge; MEM and WB advance.
- FSM enters LD_STALL for exactly one cycle, then returns to RUN.
REQ-020 MEM_WAIT entry: mem_op and !mem_ready. Behaviour while waiting:
- Entered combinationally in the same cycle; id_stall=1.
- EX, MEM and ID hold; WB receives a bubble.
- FSM stays in MEM_WAIT until mem_ready=1. On that edge the pipeline advances normally and the FSM returns to RUN.
REQ-021 Flush: mem_br_taken=1 and mem_valid=1 and the pipeline not frozen.
- flush=1 and id_stall=0.
- At the next edge EX and MEM receive bubbles; the redirecting instruction moves to WB.
REQ-022 Flush coinciding with a load-use hazard: flush wins; no stall is counted.
REQ-023 mem_br_taken with mem_valid=0 is ignored.
REQ-024 Hazards are evaluated only for valid stages; register R0 is not exempt.
REQ-025 The MEM_WAIT freeze has priority over flush and hazard; both are re-evaluated after the release edge.
REQ-026 All outputs are registered except id_stall and flush, which are combinational from state and inputs.

Reset
REQ-027 reset_n=0 immediately, regardless of clk:
- Clears every stage to a bubble.
- Forces FSM=RUN, id_stall=0, flush=0.
- Aborts any MEM_WAIT or LD_STALL in progress.
REQ-028 The first edge after deassertion behaves as RUN with empty EX/MEM/WB.

Configuration
REQ-029 Macro ALU_FWD_EN.
- Defined: EX/MEM results are forwarded, so only the REQ-019 load-use hazard stalls.
- Undefined: id_stall=1 (EX bubble, ID held) whenever a used source matches the dest of any valid EX or MEM stage with load_regfile=1.
  - Stalls last up to 2 cycles.
  - WB needs no stall because the regfile writes before it reads.
  - The FSM reuses LD_STALL for each stall cycle.

Verification
REQ-030 LDR R1 in EX (load_hazard=1, dest=1), ID=ADD R2,R1,R3 -> id_stall=1 for 1 cycle, EX bubble; ADD reaches EX on the next edge.
REQ-031 LDB in MEM, mem_ready=0 for 3 cycles -> id_stall=1 and EX/MEM contents constant for 3 cycles, WB bubbles; advance on the mem_ready=1 edge.
REQ-032 BR in MEM with mem_br_taken=1 -> flush=1, id_stall=0; next cycle ex_valid=0, mem_valid=0, wb_ctrl.opcode=op_br.
REQ-033 Flush together with a load-use hazard -> flush=1, id_stall=0, FSM stays RUN.
REQ-034 ALU_FWD_EN undefined: ADD R4 in EX, ID=NOT R5,R4 -> 2 stall cycles. With ALU_FWD_EN defined -> 0 stall cycles.
REQ-035 reset_n pulled low mid-MEM_WAIT, asynchronously to clk -> all valid bits 0, id_stall=0 within the reset assertion.

Source files
------------

// File: rtl/hazard_ctrl_pipe.sv
// LC-3b pipeline hazard controller: advances EX/MEM/WB, inserts load-use bubbles, freezes on slow memory, flushes on redirect.
// Define ALU_FWD_EN when EX/MEM results are forwarded; otherwise any RAW on a valid EX/MEM writer stalls.
package lc3b_pkg;
  typedef enum logic [3:0] {
    op_br = 4'b0000, op_add, op_ldb, op_stb, op_jsr, op_and, op_ldr, op_str,
    op_rti, op_not, op_ldi, op_sti, op_jmp, op_shf, op_lea, op_trap
  } lc3b_opcode;

  typedef struct packed {
    lc3b_opcode opcode;
    logic       load_regfile;
    logic       load_hazard;
    logic       load_cc;
    logic       mem_read;
    logic       mem_write;
    logic       mem_byte;
  } lc3b_control_word;

  typedef enum logic [1:0] {ST_RUN, ST_LD_STALL, ST_MEM_WAIT} hz_state_e;
endpackage

module hazard_ctrl_pipe
  import lc3b_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  lc3b_control_word id_ctrl,
  input  logic             id_valid,
  input  logic [2:0]       id_dest,
  input  logic [2:0]       id_sr1,
  input  logic [2:0]       id_sr2,
  input  logic             id_sr1_used,
  input  logic             id_sr2_used,
  input  logic             mem_ready,
  input  logic             mem_br_taken,
  output lc3b_control_word ex_ctrl,
  output lc3b_control_word mem_ctrl,
  output lc3b_control_word wb_ctrl,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic [2:0]       ex_dest,
  output logic [2:0]       mem_dest,
  output logic [2:0]       wb_dest,
  output logic             id_stall,
  output logic             flush,
  output hz_state_e        state_dbg
);

  typedef struct packed {
    lc3b_control_word ctrl;
    logic             valid;
    logic [2:0]       dest;
  } stage_t;

  localparam stage_t BUBBLE = '0;

  stage_t    ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_stage;
  hz_state_e state_q, state_d;
  logic      mem_op, frozen, flush_c, hazard, stall_c, hit_ex;
`ifndef ALU_FWD_EN
  logic      hit_mem;
`endif

  // Hazard detection and pipeline-control decisions.
  always_comb begin
    mem_op  = mem_q.valid &&
              (mem_q.ctrl.opcode inside {op_ldr, op_str, op_ldb, op_stb, op_ldi, op_sti, op_trap});
    // The MEM stage is held while waiting, so the state alone tracks the wait.
    frozen  = (state_q == ST_MEM_WAIT) ? !mem_ready : (mem_op && !mem_ready);
    flush_c = !frozen && mem_br_taken && mem_q.valid;
    hit_ex  = id_valid && ex_q.valid &&
              ((id_sr1_used && (id_sr1 == ex_q.dest)) || (id_sr2_used && (id_sr2 == ex_q.dest)));
`ifdef ALU_FWD_EN
    hazard  = hit_ex && ex_q.ctrl.load_hazard && ex_q.ctrl.load_regfile;
`else
    hit_mem = id_valid && mem_q.valid &&
              ((id_sr1_used && (id_sr1 == mem_q.dest)) || (id_sr2_used && (id_sr2 == mem_q.dest)));
    hazard  = (hit_ex && ex_q.ctrl.load_regfile) || (hit_mem && mem_q.ctrl.load_regfile);
`endif
    stall_c = hazard && !flush_c && !frozen;
  end

  assign id_stall = frozen || stall_c;
  assign flush    = flush_c;

  always_comb begin
    ex_d     = ex_q;
    mem_d    = mem_q;
    wb_d     = wb_q;
    state_d  = ST_RUN;
    id_stage = id_valid ? '{ctrl: id_ctrl, valid: 1'b1, dest: id_dest} : BUBBLE;
    if (frozen) begin
      wb_d    = BUBBLE;
      state_d = ST_MEM_WAIT;
    end else if (flush_c) begin
      ex_d  = BUBBLE;
      mem_d = BUBBLE;
      wb_d  = mem_q;
    end else if (stall_c) begin
      ex_d    = BUBBLE;
      mem_d   = ex_q;
      wb_d    = mem_q;
      state_d = ST_LD_STALL;
    end else begin
      ex_d  = id_stage;
      mem_d = ex_q;
      wb_d  = mem_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q    <= BUBBLE;
      mem_q   <= BUBBLE;
      wb_q    <= BUBBLE;
      state_q <= ST_RUN;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      state_q <= state_d;
    end
  end

  assign ex_ctrl   = ex_q.ctrl;
  assign ex_valid  = ex_q.valid;
  assign ex_dest   = ex_q.dest;
  assign mem_ctrl  = mem_q.ctrl;
  assign mem_valid = mem_q.valid;
  assign mem_dest  = mem_q.dest;
  assign wb_ctrl   = wb_q.ctrl;
  assign wb_valid  = wb_q.valid;
  assign wb_dest   = wb_q.dest;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Bench for hazard_ctrl_pipe: directed scenarios plus random traffic against a slot-array pipeline model.
module tb_hazard_ctrl_pipe;
  import lc3b_pkg::*;

  logic             clk = 1'b0;
  logic             reset_n;
  lc3b_control_word id_ctrl;
  logic             id_valid;
  logic [2:0]       id_dest, id_sr1, id_sr2;
  logic             id_sr1_used, id_sr2_used;
  logic             mem_ready, mem_br_taken;
  lc3b_control_word ex_ctrl, mem_ctrl, wb_ctrl;
  logic             ex_valid, mem_valid, wb_valid;
  logic [2:0]       ex_dest, mem_dest, wb_dest;
  logic             id_stall, flush;
  hz_state_e        state_dbg;

  hazard_ctrl_pipe dut (
    .clk(clk), .reset_n(reset_n), .id_ctrl(id_ctrl), .id_valid(id_valid), .id_dest(id_dest),
    .id_sr1(id_sr1), .id_sr2(id_sr2), .id_sr1_used(id_sr1_used), .id_sr2_used(id_sr2_used),
    .mem_ready(mem_ready), .mem_br_taken(mem_br_taken),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
    .id_stall(id_stall), .flush(flush), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int chk_cnt  = 0;

  // Reference pipeline: slot 0 = EX, 1 = MEM, 2 = WB.
  lc3b_control_word m_ctrl[3];
  logic             m_valid[3];
  logic [2:0]       m_dest[3];
  hz_state_e        m_state;
  logic             p_frz, p_fl, p_hz, exp_stall, exp_flush;
  logic             obs_stall, obs_flush;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    chk_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic lc3b_control_word mk(input lc3b_opcode op);
    lc3b_control_word c;
    c              = '0;
    c.opcode       = op;
    c.load_regfile = op inside {op_add, op_and, op_not, op_shf, op_lea, op_ldr, op_ldb, op_ldi, op_jsr, op_trap};
    c.load_hazard  = op inside {op_ldr, op_ldb, op_ldi};
    c.load_cc      = op inside {op_add, op_and, op_not, op_shf, op_lea, op_ldr, op_ldb, op_ldi};
    c.mem_read     = op inside {op_ldr, op_ldb, op_ldi, op_sti, op_trap};
    c.mem_write    = op inside {op_str, op_stb, op_sti};
    c.mem_byte     = op inside {op_ldb, op_stb};
    return c;
  endfunction

  task automatic set_slot(input int i, input lc3b_control_word c, input logic v, input logic [2:0] d);
    m_ctrl[i]  = c;
    m_valid[i] = v;
    m_dest[i]  = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) set_slot(i, '0, 1'b0, 3'd0);
    m_state = ST_RUN;
  endtask

  function automatic logic reads(input logic [2:0] r);
    return id_valid && ((id_sr1_used && id_sr1 == r) || (id_sr2_used && id_sr2 == r));
  endfunction

  task automatic predict();
    logic mop;
    mop   = m_valid[1] && (m_ctrl[1].opcode inside {op_ldr, op_str, op_ldb, op_stb, op_ldi, op_sti, op_trap});
    p_frz = mop && !mem_ready;
    p_fl  = !p_frz && mem_br_taken && m_valid[1];
`ifdef ALU_FWD_EN
    p_hz  = m_valid[0] && m_ctrl[0].load_hazard && m_ctrl[0].load_regfile && reads(m_dest[0]);
`else
    p_hz  = 1'b0;
    for (int s = 0; s < 2; s++)
      if (m_valid[s] && m_ctrl[s].load_regfile && reads(m_dest[s])) p_hz = 1'b1;
`endif
    exp_flush = p_fl;
    exp_stall = p_frz || (p_hz && !p_fl);
  endtask

  task automatic advance();
    if (p_frz) begin
      set_slot(2, '0, 1'b0, 3'd0);
      m_state = ST_MEM_WAIT;
    end else begin
      set_slot(2, m_ctrl[1], m_valid[1], m_dest[1]);
      if (p_fl) begin
        set_slot(1, '0, 1'b0, 3'd0);
        set_slot(0, '0, 1'b0, 3'd0);
        m_state = ST_RUN;
      end else begin
        set_slot(1, m_ctrl[0], m_valid[0], m_dest[0]);
        if (p_hz) begin
          set_slot(0, '0, 1'b0, 3'd0);
          m_state = ST_LD_STALL;
        end else begin
          if (id_valid) set_slot(0, id_ctrl, 1'b1, id_dest);
          else          set_slot(0, '0, 1'b0, 3'd0);
          m_state = ST_RUN;
        end
      end
    end
  endtask

  // One clock: check combinational and registered outputs mid-cycle, then step the model over the edge.
  task automatic cycle();
    @(negedge clk);
    predict();
    obs_stall = id_stall;
    obs_flush = flush;
    chk("id_stall", 32'(id_stall), 32'(exp_stall));
    chk("flush", 32'(flush), 32'(exp_flush));
    chk("ex_stage", 32'({ex_ctrl, ex_valid, ex_dest}), 32'({m_ctrl[0], m_valid[0], m_dest[0]}));
    chk("mem_stage", 32'({mem_ctrl, mem_valid, mem_dest}), 32'({m_ctrl[1], m_valid[1], m_dest[1]}));
    chk("wb_stage", 32'({wb_ctrl, wb_valid, wb_dest}), 32'({m_ctrl[2], m_valid[2], m_dest[2]}));
    chk("state", 32'(state_dbg), 32'(m_state));
    advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input lc3b_opcode op, input logic [2:0] d,
                        input logic u1, input logic [2:0] s1, input logic u2, input logic [2:0] s2);
    id_valid    = v;
    id_ctrl     = v ? mk(op) : '0;
    id_dest     = d;
    id_sr1_used = u1;
    id_sr1      = s1;
    id_sr2_used = u2;
    id_sr2      = s2;
  endtask

  task automatic drain();
    set_id(1'b0, op_br, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
    mem_ready    = 1'b1;
    mem_br_taken = 1'b0;
    repeat (4) cycle();
  endtask

  // Holds ID until the given opcode lands in EX; returns the number of stall cycles seen.
  task automatic run_until_ex(input lc3b_opcode op, input string tag, output int stalls);
    logic done;
    done   = 1'b0;
    stalls = 0;
    for (int k = 0; k < 6 && !done; k++) begin
      cycle();
      if (obs_stall) stalls++;
      if (ex_valid && ex_ctrl.opcode == op) done = 1'b1;
    end
    chk({tag, "_reached_ex"}, 32'(done), 32'd1);
    set_id(1'b0, op_br, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
  endtask

  initial begin
    int  stalls;
    logic hold;
    reset_n = 1'b0;
    set_id(1'b0, op_br, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
    mem_ready    = 1'b1;
    mem_br_taken = 1'b0;
    model_reset();
    #2;
    chk("rst_valids", 32'({ex_valid, mem_valid, wb_valid}), 32'd0);
    chk("rst_stall_flush", 32'({id_stall, flush}), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(ST_RUN));
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // First instruction after reset lands straight in EX.
    set_id(1'b1, op_add, 3'd3, 1'b1, 3'd1, 1'b0, 3'd0);
    cycle();
    chk("post_rst_ex", 32'({ex_valid, ex_dest}), 32'({1'b1, 3'd3}));
    drain();

    // Load-use: LDR R1 in EX, ADD R2,R1,R3 in ID.
    set_id(1'b1, op_ldr, 3'd1, 1'b1, 3'd6, 1'b0, 3'd0);
    cycle();
    set_id(1'b1, op_add, 3'd2, 1'b1, 3'd1, 1'b1, 3'd3);
    cycle();
    chk("ldu_stall", 32'(obs_stall), 32'd1);
    chk("ldu_ex_bubble", 32'(ex_valid), 32'd0);
    chk("ldu_state", 32'(state_dbg), 32'(ST_LD_STALL));
    run_until_ex(op_add, "ldu", stalls);
`ifdef ALU_FWD_EN
    chk("ldu_extra_stalls", 32'(stalls), 32'd0);
`else
    chk("ldu_extra_stalls", 32'(stalls), 32'd1);
`endif
    drain();

    // LDB in MEM waits three cycles on memory.
    set_id(1'b1, op_ldb, 3'd2, 1'b1, 3'd3, 1'b0, 3'd0);
    cycle();
    set_id(1'b1, op_add, 3'd6, 1'b1, 3'd5, 1'b0, 3'd0);
    cycle();
    set_id(1'b1, op_and, 3'd7, 1'b1, 3'd1, 1'b0, 3'd0);
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("mw_stall", 32'(obs_stall), 32'd1);
      chk("mw_hold", 32'({mem_ctrl.opcode, mem_dest, ex_dest}), 32'({op_ldb, 3'd2, 3'd6}));
      chk("mw_wb_bubble", 32'(wb_valid), 32'd0);
      chk("mw_state", 32'(state_dbg), 32'(ST_MEM_WAIT));
    end
    mem_ready = 1'b1;
    cycle();
    chk("mw_release", 32'({wb_ctrl.opcode, wb_valid, mem_dest}), 32'({op_ldb, 1'b1, 3'd6}));
    chk("mw_release_state", 32'(state_dbg), 32'(ST_RUN));
    drain();

    // Redirect from MEM.
    set_id(1'b1, op_br, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
    cycle();
    set_id(1'b1, op_add, 3'd4, 1'b1, 3'd2, 1'b0, 3'd0);
    cycle();
    mem_br_taken = 1'b1;
    cycle();
    chk("br_flush", 32'({obs_flush, obs_stall}), 32'({1'b1, 1'b0}));
    chk("br_bubbles", 32'({ex_valid, mem_valid}), 32'd0);
    chk("br_wb", 32'({wb_ctrl.opcode, wb_valid}), 32'({op_br, 1'b1}));
    mem_br_taken = 1'b0;
    drain();

    // Redirect request with an empty MEM stage is ignored.
    mem_br_taken = 1'b1;
    set_id(1'b1, op_add, 3'd4, 1'b0, 3'd0, 1'b0, 3'd0);
    cycle();
    chk("br_invalid_ignored", 32'(obs_flush), 32'd0);
    mem_br_taken = 1'b0;
    drain();

    // Flush coinciding with a load-use hazard.
    set_id(1'b1, op_br, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
    cycle();
    set_id(1'b1, op_ldr, 3'd1, 1'b1, 3'd5, 1'b0, 3'd0);
    cycle();
    set_id(1'b1, op_add, 3'd2, 1'b1, 3'd1, 1'b0, 3'd0);
    mem_br_taken = 1'b1;
    cycle();
    chk("fl_ldu_flush", 32'({obs_flush, obs_stall}), 32'({1'b1, 1'b0}));
    chk("fl_ldu_state", 32'(state_dbg), 32'(ST_RUN));
    mem_br_taken = 1'b0;
    drain();

    // ALU RAW: ADD R4 in EX, NOT R5,R4 in ID.
    set_id(1'b1, op_add, 3'd4, 1'b1, 3'd1, 1'b0, 3'd0);
    cycle();
    set_id(1'b1, op_not, 3'd5, 1'b1, 3'd4, 1'b0, 3'd0);
    run_until_ex(op_not, "alu_raw", stalls);
`ifdef ALU_FWD_EN
    chk("alu_raw_stalls", 32'(stalls), 32'd0);
`else
    chk("alu_raw_stalls", 32'(stalls), 32'd2);
`endif
    drain();

    // Asynchronous reset in the middle of a memory wait.
    set_id(1'b1, op_ldr, 3'd1, 1'b0, 3'd0, 1'b0, 3'd0);
    cycle();
    set_id(1'b0, op_br, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
    cycle();
    mem_ready = 1'b0;
    cycle();
    chk("arst_pre_state", 32'(state_dbg), 32'(ST_MEM_WAIT));
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_valids", 32'({ex_valid, mem_valid, wb_valid}), 32'd0);
    chk("arst_stall", 32'({id_stall, flush}), 32'd0);
    chk("arst_state", 32'(state_dbg), 32'(ST_RUN));
    mem_ready = 1'b1;
    model_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b1;

    // Random traffic; ID is held while the pipeline asks for a stall.
    hold = 1'b0;
    repeat (400) begin
      if (!hold)
        set_id(($urandom_range(0, 9) < 8), lc3b_opcode'($urandom_range(0, 15)),
               3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)));
      mem_ready    = ($urandom_range(0, 9) < 7);
      mem_br_taken = ($urandom_range(0, 9) < 2);
      cycle();
      hold = obs_stall;
    end
    drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
